// File: rtl/hamming_serial_decoder.sv
// Bit-serial Hamming(16,11) SECDED receiver: accumulates syndrome and
// overall parity per bit, then holds the corrected frame for handshake.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   bit_in, bit_valid    serial codeword bit and its qualifier
//   sync_in              marks an accepted bit as position 0
//   in_ready             decoder can accept a bit (RECV state)
//   out_valid, out_ready result handshake (HOLD state)
//   codeword_out         received codeword with single error inverted
//   data_out             data bits from positions 3,5,6,7,9..15
//   syndrome             XOR of indices of received 1-bits
//   corrected            single error corrected
//   double_err           uncorrectable double error detected
module hamming_serial_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        sync_in,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] codeword_out,
    output logic [10:0] data_out,
    output logic [3:0]  syndrome,
    output logic        corrected,
    output logic        double_err
);

    typedef enum logic {RECV, HOLD} state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  syn_acc;
    logic        par_acc;
    logic [15:0] shift_reg;

    logic        accept;
    logic [3:0]  pos;
    logic [3:0]  syn_fin;
    logic        par_fin;
    logic        last;
    logic [15:0] raw;
    logic [15:0] flip;
    logic [15:0] fixed;

    // sync_in restarts the frame: this bit is position 0 and the
    // accumulators see only this bit.
    always_comb begin
        accept  = bit_valid && (state == RECV);
        pos     = sync_in ? 4'd0 : idx;
        syn_fin = (sync_in ? 4'd0 : syn_acc) ^ (bit_in ? pos : 4'd0);
        par_fin = (sync_in ? 1'b0 : par_acc) ^ bit_in;
        last    = (pos == 4'd15);
        raw     = {bit_in, shift_reg[14:0]};
        flip    = par_fin ? (16'h0001 << syn_fin) : 16'h0000;
        fixed   = raw ^ flip;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RECV;
            idx          <= 4'd0;
            syn_acc      <= 4'd0;
            par_acc      <= 1'b0;
            shift_reg    <= 16'h0000;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            codeword_out <= 16'h0000;
            data_out     <= 11'h000;
            syndrome     <= 4'd0;
            corrected    <= 1'b0;
            double_err   <= 1'b0;
        end else begin
            unique case (state)
                RECV: begin
                    if (accept) begin
                        shift_reg[pos] <= bit_in;
                        if (last) begin
                            codeword_out <= fixed;
                            data_out     <= {fixed[15:9], fixed[7:5], fixed[3]};
                            syndrome     <= syn_fin;
                            corrected    <= par_fin;
                            double_err   <= (syn_fin != 4'd0) && !par_fin;
                            idx          <= 4'd0;
                            syn_acc      <= 4'd0;
                            par_acc      <= 1'b0;
                            state        <= HOLD;
                            in_ready     <= 1'b0;
                            out_valid    <= 1'b1;
                        end else begin
                            idx     <= pos + 4'd1;
                            syn_acc <= syn_fin;
                            par_acc <= par_fin;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= RECV;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Directed-vector bench for hamming_serial_decoder.
// Expected results are hand-computed SECDED decodes.
module tb_hamming_serial_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        sync_in = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] codeword_out;
    logic [10:0] data_out;
    logic [3:0]  syndrome;
    logic        corrected;
    logic        double_err;

    int checks = 0;
    int failures = 0;

    // {out_valid, in_ready, codeword, data, syndrome, corrected, double_err}
    logic [34:0] obs;
    assign obs = {out_valid, in_ready, codeword_out, data_out,
                  syndrome, corrected, double_err};

    hamming_serial_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .sync_in     (sync_in),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .codeword_out(codeword_out),
        .data_out    (data_out),
        .syndrome    (syndrome),
        .corrected   (corrected),
        .double_err  (double_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream positions lo..hi of word, optionally sync on the first bit,
    // optionally with an idle cycle after every bit.
    task automatic send_bits(input logic [15:0] word, input int lo,
                             input int hi, input logic sync_first,
                             input logic gap);
        for (int i = lo; i <= hi; i++) begin
            bit_valid = 1'b1;
            bit_in    = word[i];
            sync_in   = sync_first && (i == lo);
            tick();
            bit_valid = 1'b0;
            sync_in   = 1'b0;
            if (gap) tick();
        end
        bit_valid = 1'b0;
        sync_in   = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs !== {1'b0, 1'b1, 33'h0}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, {1'b0, 1'b1, 33'h0});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== {1'b0, 1'b1, 33'h0}) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", obs, {1'b0, 1'b1, 33'h0});
        end
    endtask

    task automatic test_clean();
        logic [34:0] exp;
        exp = {1'b1, 1'b0, 16'h000F, 11'h001, 4'd0, 1'b0, 1'b0};
        send_bits(16'h000F, 0, 14, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clean_early got ov=%b ir=%b exp ov=0 ir=1",
                     out_valid, in_ready);
        end
        send_bits(16'h000F, 15, 15, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clean_result got=%h exp=%h", obs, exp);
        end
        drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clean_drain got ov=%b ir=%b exp ov=0 ir=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_single();
        logic [34:0] exp;
        exp = {1'b1, 1'b0, 16'h000F, 11'h001, 4'd6, 1'b1, 1'b0};
        send_bits(16'h004F, 0, 15, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL single_pos6 got=%h exp=%h", obs, exp);
        end
        drain();
        exp = {1'b1, 1'b0, 16'h000F, 11'h001, 4'd0, 1'b1, 1'b0};
        send_bits(16'h000E, 0, 15, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL single_par got=%h exp=%h", obs, exp);
        end
        drain();
    endtask

    task automatic test_double();
        logic [34:0] exp;
        exp = {1'b1, 1'b0, 16'h024F, 11'h015, 4'd15, 1'b0, 1'b1};
        send_bits(16'h024F, 0, 15, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL double got=%h exp=%h", obs, exp);
        end
        drain();
    endtask

    task automatic test_gaps();
        logic [34:0] exp;
        exp = {1'b1, 1'b0, 16'h8117, 11'h400, 4'd12, 1'b1, 1'b0};
        send_bits(16'h9117, 0, 15, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL gaps got=%h exp=%h", obs, exp);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [34:0] exp;
        logic [34:0] exp2;
        exp  = {1'b1, 1'b0, 16'h000F, 11'h001, 4'd6, 1'b1, 1'b0};
        exp2 = {1'b1, 1'b0, 16'h000F, 11'h001, 4'd0, 1'b0, 1'b0};
        send_bits(16'h004F, 0, 15, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            sync_in   = c[0];
            tick();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL bp_hold%0d got=%h exp=%h", c, obs, exp);
            end
        end
        bit_valid = 1'b0;
        sync_in   = 1'b0;
        drain();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0",
                     in_ready, out_valid);
        end
        send_bits(16'h000F, 0, 15, 1'b0, 1'b0);
        checks++;
        if (obs !== exp2) begin
            failures++;
            $display("FAIL bp_next got=%h exp=%h", obs, exp2);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [34:0] exp;
        out_ready = 1'b1;
        exp = {1'b1, 1'b0, 16'h8117, 11'h400, 4'd0, 1'b0, 1'b0};
        send_bits(16'h8117, 0, 15, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=%h", obs, exp);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready got ir=%b ov=%b exp ir=1 ov=0",
                     in_ready, out_valid);
        end
        exp = {1'b1, 1'b0, 16'h8117, 11'h400, 4'd12, 1'b1, 1'b0};
        send_bits(16'h9117, 0, 15, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL b2b_second got=%h exp=%h", obs, exp);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_resync();
        logic [34:0] exp;
        exp = {1'b1, 1'b0, 16'h000F, 11'h001, 4'd6, 1'b1, 1'b0};
        send_bits(16'hFFFF, 0, 6, 1'b0, 1'b0);
        send_bits(16'h004F, 0, 15, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL resync got=%h exp=%h", obs, exp);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        logic [34:0] exp;
        exp = {1'b1, 1'b0, 16'h000F, 11'h001, 4'd0, 1'b0, 1'b0};
        send_bits(16'h0FFF, 0, 9, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs !== {1'b0, 1'b1, 33'h0}) begin
            failures++;
            $display("FAIL midrst_during got=%h exp=%h", obs, {1'b0, 1'b1, 33'h0});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== {1'b0, 1'b1, 33'h0}) begin
            failures++;
            $display("FAIL midrst_after got=%h exp=%h", obs, {1'b0, 1'b1, 33'h0});
        end
        send_bits(16'h000F, 0, 15, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL midrst_frame got=%h exp=%h", obs, exp);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (obs !== {1'b0, 1'b1, 33'h0}) begin
            failures++;
            $display("FAIL holdrst got=%h exp=%h", obs, {1'b0, 1'b1, 33'h0});
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_gaps();
        test_backpressure();
        test_back_to_back();
        test_resync();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
